orb_bank_scheduler: RTL and testbench

ORB_BANK_SCHEDULER -- requirements
Module: orb_bank_scheduler

---
 rtl/orb_bank_scheduler_if.sv | 39 +++
 rtl/orb_bank_scheduler.sv | 76 +++++++
 tb/tb_orb_bank_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/orb_bank_scheduler_if.sv
// orb_bank_scheduler_if: frame, writer, reader, bank and status signals of the orbit bank scheduler
// Modports: slave = scheduler side, master = environment side (frame filler, reader, RAMs).
// With ORB_OVERRUN_COUNT_EN defined the 8-bit overrunCount status signal is added.
interface orb_bank_scheduler_if;
  logic frameTick, clearOverrun;
  logic [11:0] wrData;
  logic [9:0] wrAddr;
  logic wrEn;
  logic [9:0] rdAddr;
  logic rdEn;
  logic [11:0] rdData;
  logic rdValid;
  logic [9:0] bankAAddr, bankBAddr;
  logic [11:0] bankAData, bankBData;
  logic bankAWrEn, bankBWrEn;
  logic [11:0] bankARdData, bankBRdData;
  logic orbSwitch, wrBank, fillDone, overrun;
`ifdef ORB_OVERRUN_COUNT_EN
  logic [7:0] overrunCount;
`endif
  modport slave(
    input frameTick, clearOverrun, wrData, wrAddr, wrEn, rdAddr, rdEn, bankARdData, bankBRdData,
    output
`ifdef ORB_OVERRUN_COUNT_EN
    overrunCount,
`endif
    rdData, rdValid, bankAAddr, bankBAddr, bankAData, bankBData, bankAWrEn, bankBWrEn,
    orbSwitch, wrBank, fillDone, overrun
  );
  modport master(
    output frameTick, clearOverrun, wrData, wrAddr, wrEn, rdAddr, rdEn, bankARdData, bankBRdData,
    input
`ifdef ORB_OVERRUN_COUNT_EN
    overrunCount,
`endif
    rdData, rdValid, bankAAddr, bankBAddr, bankAData, bankBData, bankAWrEn, bankBWrEn,
    orbSwitch, wrBank, fillDone, overrun
  );
endinterface

// File: rtl/orb_bank_scheduler.sv
// orb_bank_scheduler: ping-pong orbit bank scheduler (one bank filled while the other is read)
// Ports: clk (80 MHz), reset (async, active-low), bus (orb_bank_scheduler_if.slave):
//   frame inputs frameTick/clearOverrun, writer wrData/wrAddr/wrEn, reader rdAddr/rdEn -> rdData/rdValid,
//   bank A/B address/data/write-enable outputs with 1-cycle-latency read data inputs,
//   status orbSwitch/wrBank/fillDone/overrun.
// Option: define ORB_OVERRUN_COUNT_EN to add the saturating 8-bit overrunCount status.
module orb_bank_scheduler (
  input logic clk,
  input logic reset,
  orb_bank_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, FULL, SWAP} state_t;
  state_t state, nextState;
  logic wrEnQ, pendingTick, rdEnQ, rdSelQ;
  logic [9:0] lastAddr;
  logic fillWr, complete, overrunEvt;
  assign fillWr = state == FILL && bus.wrEn;
  // wrEnQ only tracks accepted writes, so a falling edge is only seen after real FILL writes
  assign complete = state == FILL && wrEnQ && !bus.wrEn && lastAddr == 10'd1023;
  // a tick coinciding with completion is a normal frame boundary, not an overrun
  assign overrunEvt = state == FILL && bus.frameTick && !complete;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: nextState = bus.frameTick ? SWAP : IDLE;
      SWAP: nextState = FILL;
      FILL: nextState = complete ? FULL : FILL;
      FULL: nextState = (bus.frameTick || pendingTick) ? SWAP : FULL;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wrEnQ <= 1'b0;
      lastAddr <= '0;
      pendingTick <= 1'b0;
      bus.orbSwitch <= 1'b0;
      bus.wrBank <= 1'b0;
      bus.fillDone <= 1'b0;
      bus.overrun <= 1'b0;
      rdEnQ <= 1'b0;
      rdSelQ <= 1'b0;
      bus.rdValid <= 1'b0;
      bus.rdData <= '0;
    end else begin
      wrEnQ <= fillWr;
      lastAddr <= state == SWAP ? '0 : fillWr ? bus.wrAddr : lastAddr;
      pendingTick <= complete ? bus.frameTick : state == SWAP ? 1'b0 : pendingTick;
      bus.orbSwitch <= bus.orbSwitch ^ (state == SWAP);
      // fillDone is still set in SWAP only when we arrived from FULL, i.e. a bank was completed
      bus.wrBank <= bus.wrBank ^ (state == SWAP && bus.fillDone);
      bus.fillDone <= complete | (bus.fillDone & (state != SWAP));
      bus.overrun <= overrunEvt | (bus.overrun & !bus.clearOverrun);
      // bank choice is frozen at request time so a following SWAP cannot redirect it
      rdEnQ <= bus.rdEn;
      rdSelQ <= !bus.wrBank;
      bus.rdValid <= rdEnQ;
      bus.rdData <= rdEnQ ? (rdSelQ ? bus.bankBRdData : bus.bankARdData) : bus.rdData;
    end
`ifdef ORB_OVERRUN_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) bus.overrunCount <= '0;
    else bus.overrunCount <= bus.clearOverrun ? {7'd0, overrunEvt} :
                             bus.overrunCount + {7'd0, overrunEvt && bus.overrunCount != 8'hFF};
`endif
  always_comb begin
    bus.bankAAddr = bus.wrBank ? bus.rdAddr : bus.wrAddr;
    bus.bankBAddr = bus.wrBank ? bus.wrAddr : bus.rdAddr;
    bus.bankAData = bus.wrData;
    bus.bankBData = bus.wrData;
    bus.bankAWrEn = fillWr && !bus.wrBank;
    bus.bankBWrEn = fillWr && bus.wrBank;
  end
endmodule

// File: tb/tb_orb_bank_scheduler.sv
// tb_orb_bank_scheduler: randomized self-checking bench for orb_bank_scheduler
module tb_orb_bank_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  orb_bank_scheduler_if bus();
  orb_bank_scheduler dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [11:0] ramA [1024];
  logic [11:0] ramB [1024];
  always @(posedge clk) begin
    if (bus.bankAWrEn) ramA[bus.bankAAddr] <= bus.bankAData;
    if (bus.bankBWrEn) ramB[bus.bankBAddr] <= bus.bankBData;
    bus.bankARdData <= ramA[bus.bankAAddr];
    bus.bankBRdData <= ramB[bus.bankBAddr];
  end
  int total, passed;
  logic [11:0] mdl [2][1024];
  int expRdBank;
  bit autoRead, contRead;
  logic [12:0] pipe [$];
  task automatic step();
    logic [12:0] e;
    if (autoRead) begin
      bus.rdEn = contRead | 1'($urandom_range(0, 1));
      bus.rdAddr = 10'($urandom_range(0, 1023));
    end
    pipe.push_back({bus.rdEn, bus.rdEn ? mdl[expRdBank][bus.rdAddr] : 12'd0});
    @(posedge clk);
    #1;
    if (pipe.size() == 2) begin
      e = pipe.pop_front();
      total++;
      if (bus.rdValid !== e[12] || (e[12] && bus.rdData !== e[11:0]))
        $display("FAIL read: rdValid=%b rdData=%h required rdValid=%b rdData=%h", bus.rdValid, bus.rdData, e[12], e[11:0]);
      else passed++;
    end
  endtask
  task automatic fillRange(input int bank, input int lo, input int hi, input bit addrData);
    for (int a = lo; a <= hi; a++) begin
      bus.wrEn = 1'b1;
      bus.wrAddr = 10'(a);
      bus.wrData = addrData ? 12'(a) : 12'($urandom);
      mdl[bank][a] = bus.wrData;
      #1;
      total++;
      if ((bank ? {bus.bankAWrEn, bus.bankBWrEn, bus.bankBAddr, bus.bankBData}
                : {bus.bankAWrEn, bus.bankBWrEn, bus.bankAAddr, bus.bankAData})
          !== {(bank ? 2'b01 : 2'b10), bus.wrAddr, bus.wrData})
        $display("FAIL fill_write: addr=%0d wrEn A/B=%b%b required bank %0d only", a, bus.bankAWrEn, bus.bankBWrEn, bank);
      else passed++;
      step();
    end
  endtask
  task automatic test_reset();
    {bus.frameTick, bus.clearOverrun, bus.rdEn} = '0;
    bus.wrData = '0;
    bus.wrAddr = '0;
    bus.rdAddr = '0;
    bus.wrEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun, bus.rdValid, bus.bankAWrEn, bus.bankBWrEn} !== 7'b0 || bus.rdData !== 12'd0)
      $display("FAIL reset: status=%b rdData=%h required all 0", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun, bus.rdValid, bus.bankAWrEn, bus.bankBWrEn}, bus.rdData);
    else passed++;
    bus.wrEn = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_first_swap();
    bus.frameTick = 1'b1;
    bus.wrEn = 1'b1;
    bus.wrAddr = 10'd7;
    #1;
    total++;
    if ({bus.bankAWrEn, bus.bankBWrEn} !== 2'b00) $display("FAIL idle_wren: A/B=%b%b required 00", bus.bankAWrEn, bus.bankBWrEn);
    else passed++;
    step();
    bus.frameTick = 1'b0;
    #1;
    total++;
    if ({bus.orbSwitch, bus.bankAWrEn, bus.bankBWrEn} !== 3'b000)
      $display("FAIL swap_cycle: orbSwitch/A/B=%b required 000", {bus.orbSwitch, bus.bankAWrEn, bus.bankBWrEn});
    else passed++;
    step();
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b1000)
      $display("FAIL first_swap: status=%b required 1000", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
    bus.wrEn = 1'b0;
  endtask
  task automatic test_fill_a();
    autoRead = 1'b0;
    bus.rdEn = 1'b0;
    fillRange(0, 0, 1023, 1'b1);
    bus.wrEn = 1'b0;
    step();
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b1010)
      $display("FAIL fill_done: status=%b required 1010", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
    bus.frameTick = 1'b1;
    step();
    bus.frameTick = 1'b0;
    step();
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b0100)
      $display("FAIL swap_to_b: status=%b required 0100", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
    expRdBank = 0;
    bus.rdEn = 1'b1;
    bus.rdAddr = 10'd5;
    step();
    bus.rdEn = 1'b0;
    step();
    total++;
    if (bus.rdValid !== 1'b1 || bus.rdData !== 12'd5) $display("FAIL read_addr5: rdValid=%b rdData=%h required 1 005", bus.rdValid, bus.rdData);
    else passed++;
    autoRead = 1'b1;
    contRead = 1'b0;
    repeat (40) step();
  endtask
  task automatic test_swap_reads();
    contRead = 1'b1;
    fillRange(1, 0, 1023, 1'b0);
    bus.wrEn = 1'b0;
    bus.frameTick = 1'b1;
    step();
    bus.frameTick = 1'b0;
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b0110)
      $display("FAIL coincident_done: status=%b required 0110", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
    step();
    step();
    expRdBank = 1;
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b1000)
      $display("FAIL coincident_swap: status=%b required 1000", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
    repeat (20) step();
  endtask
  task automatic test_overrun();
    contRead = 1'b0;
    fillRange(0, 0, 511, 1'b0);
    bus.wrEn = 1'b1;
    bus.wrAddr = 10'd512;
    bus.wrData = 12'($urandom);
    mdl[0][512] = bus.wrData;
    bus.frameTick = 1'b1;
    step();
    bus.frameTick = 1'b0;
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b1001)
      $display("FAIL overrun_set: status=%b required 1001", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
`ifdef ORB_OVERRUN_COUNT_EN
    total++;
    if (bus.overrunCount !== 8'd1) $display("FAIL overrun_count1: %0d required 1", bus.overrunCount);
    else passed++;
`endif
    fillRange(0, 513, 600, 1'b0);
    bus.wrEn = 1'b0;
    repeat (299) begin
      bus.frameTick = 1'b1;
      step();
    end
    bus.frameTick = 1'b0;
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b1001)
      $display("FAIL overrun_hold: status=%b required 1001", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
`ifdef ORB_OVERRUN_COUNT_EN
    total++;
    if (bus.overrunCount !== 8'd255) $display("FAIL overrun_sat: %0d required 255", bus.overrunCount);
    else passed++;
`endif
    bus.clearOverrun = 1'b1;
    step();
    bus.clearOverrun = 1'b0;
    step();
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun} !== 4'b1000)
      $display("FAIL overrun_clear: status=%b required 1000", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun});
    else passed++;
`ifdef ORB_OVERRUN_COUNT_EN
    total++;
    if (bus.overrunCount !== 8'd0) $display("FAIL overrun_count_clear: %0d required 0", bus.overrunCount);
    else passed++;
`endif
    bus.clearOverrun = 1'b1;
    bus.frameTick = 1'b1;
    step();
    {bus.clearOverrun, bus.frameTick} = 2'b00;
    total++;
    if (bus.overrun !== 1'b1) $display("FAIL overrun_wins: overrun=%b required 1", bus.overrun);
    else passed++;
  endtask
  task automatic test_reset_midfill();
    contRead = 1'b1;
    bus.wrEn = 1'b1;
    bus.wrAddr = 10'd300;
    bus.wrData = 12'($urandom);
    mdl[0][300] = bus.wrData;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun, bus.rdValid, bus.bankAWrEn, bus.bankBWrEn} !== 7'b0 || bus.rdData !== 12'd0)
      $display("FAIL async_reset: status=%b rdData=%h required all 0", {bus.orbSwitch, bus.wrBank, bus.fillDone, bus.overrun, bus.rdValid, bus.bankAWrEn, bus.bankBWrEn}, bus.rdData);
    else passed++;
`ifdef ORB_OVERRUN_COUNT_EN
    total++;
    if (bus.overrunCount !== 8'd0) $display("FAIL reset_count: %0d required 0", bus.overrunCount);
    else passed++;
`endif
    pipe.delete();
    autoRead = 1'b0;
    bus.rdEn = 1'b0;
    #2 reset = 1'b1;
    repeat (5) begin
      step();
      total++;
      if ({bus.bankAWrEn, bus.bankBWrEn, bus.orbSwitch} !== 3'b000)
        $display("FAIL post_reset_wren: A/B/orbSwitch=%b required 000", {bus.bankAWrEn, bus.bankBWrEn, bus.orbSwitch});
      else passed++;
    end
    bus.frameTick = 1'b1;
    step();
    bus.frameTick = 1'b0;
    step();
    total++;
    if ({bus.orbSwitch, bus.wrBank, bus.bankAWrEn, bus.bankBWrEn} !== 4'b1010)
      $display("FAIL restart_fill: orbSwitch/wrBank/A/B=%b required 1010", {bus.orbSwitch, bus.wrBank, bus.bankAWrEn, bus.bankBWrEn});
    else passed++;
    bus.wrEn = 1'b0;
  endtask
  initial begin
    total = 0;
    passed = 0;
    expRdBank = 1;
    autoRead = 1'b0;
    contRead = 1'b0;
    test_reset();
    test_first_swap();
    test_fill_a();
    test_swap_reads();
    test_overrun();
    test_reset_midfill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 ns");
    $fatal(1);
  end
endmodule
